// File: rtl/ise_sort_scheduler_pkg.sv
// Shared types and constants for the ISE result-ordering scheduler.
// Holds table entry layout, color codes and FSM states.
package ise_pkg;

  localparam int IMAGE_NUM = 32;
  localparam int IDX_W     = 5;
  localparam int METRIC_W  = 22;

  localparam logic [1:0] COLOR_R = 2'd0;
  localparam logic [1:0] COLOR_G = 2'd1;
  localparam logic [1:0] COLOR_B = 2'd2;

  typedef struct packed {
    logic [1:0]          color;
    logic [METRIC_W-1:0] metric;
  } ise_result_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCAN    = 2'd1,
    EMIT    = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef logic [IDX_W:0] cnt_t;

  function automatic logic [1:0] sat_color(
    input logic [1:0] c
  );
    return (c == 2'd3) ? COLOR_B : c;
  endfunction

endpackage

// File: rtl/ise_sort_scheduler_if.sv
// Result input and sorted output bundle of the scheduler.
// master = result source / output sink, slave = scheduler.
interface ise_sort_scheduler_if;
  import ise_pkg::*;

  logic                res_valid;
  logic                res_ready;
  logic [IDX_W-1:0]    res_index;
  logic [1:0]          res_color;
  logic [METRIC_W-1:0] res_metric;
  logic                out_valid;
  logic [1:0]          color_index;
  logic [IDX_W-1:0]    image_out_index;
  logic                done;

  modport master (
    output res_valid,
    output res_index,
    output res_color,
    output res_metric,
    input  res_ready,
    input  out_valid,
    input  color_index,
    input  image_out_index,
    input  done
  );

  modport slave (
    input  res_valid,
    input  res_index,
    input  res_color,
    input  res_metric,
    output res_ready,
    output out_valid,
    output color_index,
    output image_out_index,
    output done
  );

endinterface

// File: rtl/ise_sort_scheduler_key_cmp.sv
// Strict "a beats b" on (color asc, metric desc).
// Index order is resolved by the scan walking low to high.
module ise_key_cmp
  import ise_pkg::*;
(
  input  ise_result_t a,
  input  ise_result_t b,
  output logic        better
);

  always_comb begin
    better = 1'b0;
    unique case (1'b1)
      (a.color < b.color): better = 1'b1;
      (a.color > b.color): better = 1'b0;
      default:             better = (a.metric > b.metric);
    endcase
  end

endmodule

// File: rtl/ise_sort_scheduler.sv
// Collects one result per image, then emits images in key order
// using a one-entry-per-cycle selection scan over the result table.
module ise_sort_scheduler
  import ise_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  ise_sort_scheduler_if.slave  bus
);

  localparam logic [IDX_W-1:0] P_LAST = IDX_W'(IMAGE_NUM - 1);
  localparam cnt_t             C_LAST = cnt_t'(IMAGE_NUM - 1);

  state_t state;
  state_t state_nx;

  logic [IDX_W-1:0]     p;
  cnt_t                 fill_cnt;
  cnt_t                 out_cnt;
  logic [IMAGE_NUM-1:0] filled;
  logic [IMAGE_NUM-1:0] sent;

  ise_result_t table_q [IMAGE_NUM];
  ise_result_t cand;
  ise_result_t best;
  logic        best_vld;
  logic [IDX_W-1:0] best_idx;

  logic better;
  logic take;
  logic acc;
  logic fill_new;
  logic last_fill;
  logic last_out;

  logic             ready_q;
  logic             valid_q;
  logic [1:0]       color_q;
  logic [IDX_W-1:0] index_q;
  logic             done_q;

  logic             ready_d;
  logic             valid_d;
  logic [1:0]       color_d;
  logic [IDX_W-1:0] index_d;
  logic             done_d;

  assign acc       = bus.res_valid & ready_q;
  assign fill_new  = ~filled[bus.res_index];
  assign last_fill = acc & fill_new & (fill_cnt == C_LAST);
  assign last_out  = (out_cnt == C_LAST);
  assign cand      = table_q[p];

  // p==0 reseeds the search, so a stale best never survives a pass
  assign take = ~sent[p] & ((p == '0) | ~best_vld | better);

  ise_key_cmp u_cmp (
    .a      (cand),
    .b      (best),
    .better (better)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= COLLECT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      COLLECT: if (last_fill) state_nx = SCAN;
      SCAN:    if (p == P_LAST) state_nx = EMIT;
      EMIT:    state_nx = last_out ? DONE : SCAN;
      DONE:    state_nx = COLLECT;
      default: state_nx = COLLECT;
    endcase
  end

  // ready stays low through the done cycle of a batch
  always_comb begin
    ready_d = (state == COLLECT) && (state_nx == COLLECT);
    valid_d = (state == EMIT);
    done_d  = (state == DONE);
    color_d = color_q;
    index_d = index_q;
    if (state == EMIT) begin
      color_d = best.color;
      index_d = best_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      color_q <= '0;
      index_q <= '0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= ready_d;
      valid_q <= valid_d;
      color_q <= color_d;
      index_q <= index_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p        <= '0;
      fill_cnt <= '0;
      out_cnt  <= '0;
      filled   <= '0;
      sent     <= '0;
      best_vld <= 1'b0;
      best_idx <= '0;
      best     <= '0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (acc) begin
            filled[bus.res_index] <= 1'b1;
            if (fill_new) fill_cnt <= fill_cnt + 1'b1;
          end
        end
        SCAN: begin
          p <= p + 1'b1;
          if (take) begin
            best_vld <= 1'b1;
            best_idx <= p;
            best     <= cand;
          end else if (p == '0) begin
            best_vld <= 1'b0;
          end
        end
        EMIT: begin
          sent[best_idx] <= 1'b1;
          out_cnt        <= out_cnt + 1'b1;
        end
        DONE: begin
          p        <= '0;
          fill_cnt <= '0;
          out_cnt  <= '0;
          filled   <= '0;
          sent     <= '0;
          best_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      table_q[bus.res_index] <= '{
        color:  sat_color(bus.res_color),
        metric: bus.res_metric
      };
    end
  end

  assign bus.res_ready       = ready_q;
  assign bus.out_valid       = valid_q;
  assign bus.color_index     = color_q;
  assign bus.image_out_index = index_q;
  assign bus.done            = done_q;

endmodule

// File: tb/tb_ise_sort_scheduler.sv
// Scoreboard bench for ise_sort_scheduler: a key-sorting model feeds
// an expected-output queue checked by an independent monitor.
module tb_ise_sort_scheduler;
  import ise_pkg::*;

  typedef struct {
    int idx;
    int color;
    int metric;
  } res_t;

  typedef struct {
    int color;
    int idx;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ise_sort_scheduler_if bus();

  ise_sort_scheduler dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  exp_t cur;
  int checks      = 0;
  int errors      = 0;
  int cyc         = 0;
  int last_accept = 0;
  int k           = 0;
  int done_cnt    = 0;
  int exp_done    = 0;
  bit chk_ready   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every strobe pops one expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_ready) begin
        chk_ready = 1'b0;
        checks++;
        if (bus.res_ready !== 1'b1) begin
          errors++;
          $display("FAIL ready_after_done: got %b want 1", bus.res_ready);
        end
      end
      if (bus.out_valid === 1'b1) begin
        k++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: idx %0d with empty scoreboard",
                   bus.image_out_index);
        end else begin
          cur = sb.pop_front();
          if (bus.image_out_index !== 5'(cur.idx) ||
              bus.color_index !== 2'(cur.color)) begin
            errors++;
            $display("FAIL out_order #%0d: got idx %0d col %0d want idx %0d col %0d",
                     k, bus.image_out_index, bus.color_index, cur.idx, cur.color);
          end
        end
        checks++;
        if (cyc != last_accept + 33 * k) begin
          errors++;
          $display("FAIL out_timing #%0d: got cycle %0d want %0d",
                   k, cyc, last_accept + 33 * k);
        end
        checks++;
        if (bus.res_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_busy: got %b want 0", bus.res_ready);
        end
      end
      if (bus.done === 1'b1) begin
        checks++;
        if (k != 32 || cyc != last_accept + 32 * 33 + 1 ||
            bus.out_valid !== 1'b0 || bus.res_ready !== 1'b0) begin
          errors++;
          $display("FAIL done_pulse: got outs %0d cyc %0d ov %b rdy %b want 32 %0d 0 0",
                   k, cyc, bus.out_valid, bus.res_ready,
                   last_accept + 32 * 33 + 1);
        end
        k = 0;
        done_cnt++;
        chk_ready = 1'b1;
      end
    end
  end

  // reference: sort on one composite integer key
  task automatic push_expected(input res_t q[$]);
    int col[32];
    int met[32];
    longint keys[$];
    foreach (q[i]) begin
      col[q[i].idx] = (q[i].color == 3) ? 2 : q[i].color;
      met[q[i].idx] = q[i].metric;
    end
    for (int i = 0; i < 32; i++) begin
      keys.push_back(longint'(col[i]) * 134217728 +
                     longint'(4194303 - met[i]) * 32 + longint'(i));
    end
    keys.sort();
    foreach (keys[j]) begin
      sb.push_back('{color: int'(keys[j] / 134217728),
                     idx: int'(keys[j] % 32)});
    end
  endtask

  task automatic send(input res_t r);
    int n = 0;
    @(negedge clk);
    bus.res_valid  = 1'b1;
    bus.res_index  = 5'(r.idx);
    bus.res_color  = 2'(r.color);
    bus.res_metric = 22'(r.metric);
    while (bus.res_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (bus.res_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: res_ready %b want 1", bus.res_ready);
      bus.res_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_accept   = cyc;
    bus.res_valid = 1'b0;
  endtask

  task automatic send_batch(input res_t q[$], input bit gaps);
    push_expected(q);
    foreach (q[i]) begin
      send(q[i]);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt != target || sb.size() != 0) begin
      errors++;
      $display("FAIL batch_end: done %0d left %0d want done %0d left 0",
               done_cnt, sb.size(), target);
    end
  endtask

  task automatic chk_reset(input string tag);
    checks++;
    if (bus.res_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.color_index !== 2'd0 || bus.image_out_index !== 5'd0 ||
        bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s: rdy %b ov %b col %0d idx %0d done %b want 1 0 0 0 0",
               tag, bus.res_ready, bus.out_valid, bus.color_index,
               bus.image_out_index, bus.done);
    end
  endtask

  function automatic void rand_batch(output res_t q[$], input bit wide);
    int perm[32];
    int t;
    int j;
    q.delete();
    for (int i = 0; i < 32; i++) perm[i] = i;
    for (int i = 31; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < 32; i++) begin
      q.push_back('{idx: perm[i], color: $urandom_range(0, 3),
                    metric: wide ? int'($urandom & 32'h3FFFFF)
                                 : $urandom_range(0, 3)});
      if (i < 31 && $urandom_range(0, 7) == 0) begin
        q.push_back('{idx: perm[$urandom_range(0, i)],
                      color: $urandom_range(0, 3),
                      metric: wide ? int'($urandom & 32'h3FFFFF)
                                   : $urandom_range(0, 3)});
      end
    end
  endfunction

  res_t q[$];
  res_t q2[$];

  initial begin
    int n;
    bus.res_valid  = 1'b0;
    bus.res_index  = '0;
    bus.res_color  = '0;
    bus.res_metric = '0;
    repeat (3) @(negedge clk);
    chk_reset("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    q.delete();
    q.push_back('{idx: 0, color: 2, metric: 5});
    q.push_back('{idx: 1, color: 0, metric: 9});
    q.push_back('{idx: 2, color: 1, metric: 7});
    q.push_back('{idx: 3, color: 0, metric: 3});
    for (int i = 4; i < 32; i++) q.push_back('{idx: i, color: 2, metric: 0});
    send_batch(q, 1'b0);
    exp_done++;
    wait_done(exp_done);

    rand_batch(q, 1'b0);
    foreach (q[i]) begin
      q[i].color  = 1;
      q[i].metric = 100;
    end
    send_batch(q, 1'b1);
    exp_done++;
    wait_done(exp_done);

    q.delete();
    q.push_back('{idx: 7, color: 0, metric: 1});
    q.push_back('{idx: 7, color: 0, metric: 50});
    for (int i = 0; i < 32; i++)
      if (i != 7) q.push_back('{idx: i, color: 0, metric: 10});
    send_batch(q, 1'b0);
    exp_done++;
    wait_done(exp_done);

    rand_batch(q, 1'b1);
    send_batch(q, 1'b1);
    n = 0;
    while (k < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    chk_ready = 1'b0;
    #1;
    chk_reset("reset_mid_scan");
    sb.delete();
    k = 0;
    repeat (3) @(negedge clk);
    chk_reset("reset_hold");
    rst_n = 1'b1;
    rand_batch(q, 1'b1);
    send_batch(q, 1'b1);
    exp_done++;
    wait_done(exp_done);

    rand_batch(q, 1'b1);
    rand_batch(q2, 1'b0);
    send_batch(q, 1'b0);
    send_batch(q2, 1'b0);
    exp_done += 2;
    wait_done(exp_done);

    for (int b = 0; b < 2; b++) begin
      rand_batch(q, b[0]);
      send_batch(q, 1'b1);
      exp_done++;
      wait_done(exp_done);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
